// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns PC and IDLE/RUN/HALT control for the accumulator core,
// resolves decode jump enables into the next PC, and counts RUN cycles with an optional watchdog.
module pc_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned OFF_W      = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             done_req,
    input  logic             absjump_en,
    input  logic             reljump_en,
    input  logic             compare_en,
    input  logic             compare_eq,
    input  logic [PC_W-1:0]  abs_target,
    input  logic [OFF_W-1:0] rel_offset,
    output logic [PC_W-1:0]  pc,
    output logic             run_en,
    output logic             done_out,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    localparam bit          WdEn   = (MAX_CYCLES != 0);
    localparam int unsigned WdLast = WdEn ? MAX_CYCLES - 1 : 0;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_rel;
    logic             wd_hit;
    logic             rel_taken;

    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        pc_seq    = pc_q + PC_W'(1);
        // Size cast of a signed operand sign-extends the offset before the modular add.
        pc_rel    = pc_q + PC_W'($signed(rel_offset));
        wd_hit    = WdEn && (32'(cnt_q) == WdLast);
        rel_taken = reljump_en && (!compare_en || compare_eq);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d      = start_addr;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_inc;
                if (done_req) begin
                    done_d  = 1'b1;
                    state_d = StHalt;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StHalt;
                end else if (absjump_en) begin
                    pc_d = abs_target;
                end else if (rel_taken) begin
                    pc_d = pc_rel;
                end else begin
                    pc_d = pc_seq;
                end
            end
            StHalt: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        run_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc          = pc_q;
    assign run_en      = run_q;
    assign done_out    = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;

endmodule
